tt_um_jimktrains_vslc_counter: RTL and testbench
================================================

Name: tt_um_jimktrains_vslc_counter

Overview:
- PLC-style up/down preset counter for the VSLC.
- Sits directly downstream of the VSLC timer and consumes its square-wave output, or an external pin, as the count source.
- Counts rising edges of that source and flags when the terminal count is reached.
- Supports one-shot (hold) and auto-reload modes, with a sticky overflow flag for edges that are dropped.

Parameters:
- WIDTH, 8, counter and preset width.
- DEBOUNCE_CYCLES, 4, filter length; only used when VSLC_CTR_DEBOUNCE_EN is defined.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- count_in  input  1  count source (timer_output or pin); rising edges are counted.
- enable  input  1  counter enable; low = idle and clear.
- dir  input  1  0 = count up from 0 to preset, 1 = count down from preset to 0.
- preset  input  WIDTH  terminal/start value; latched into preset_q.
- load  input  1  restart request while enabled.
- auto_reload  input  1  0 = one-shot (hold in DONE), 1 = reload and continue.
- count  output  WIDTH  current count.
- done  output  1  terminal count reached.
- overflow  output  1  sticky: an edge arrived that could not be counted.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, count=0, preset_q=0, count_in_q=0, done=0, overflow=0.
- Edge detect:
  - count_in_q <= count_in every cycle, including in IDLE, so enabling while count_in is high produces no edge.
  - edge = count_in & ~count_in_q.
  - count changes on the first clk edge at which count_in is sampled 1 after a sample of 0.
- Priority: reset > !enable > load > edge.
- Start value: 0 if dir=0, otherwise the preset_q value.
- Terminal value: preset_q if dir=0, otherwise 0.
- Both start and terminal use the current dir.
- IDLE (enable=0):
  - preset_q <= preset; count <= start value computed from preset.
  - done=0, overflow=0. Next state is COUNTING when enable=1.
- load=1 while enabled:
  - preset_q <= preset; count <= start value; overflow cleared; state=COUNTING; done=0.
- COUNTING:
  - If count == terminal: next state DONE, done=1 on the following cycle. Any edge in that same cycle is not counted and sets overflow.
  - Otherwise an edge increments (dir=0) or decrements (dir=1) count.
- DONE with auto_reload=0:
  - Hold count and done=1.
  - Each edge sets overflow.
  - Leave only on load or !enable.
- DONE with auto_reload=1:
  - done is high for exactly 1 cycle; count <= start value; next state COUNTING.
  - An edge in that cycle is not counted and sets overflow.
- Range and width rules:
  - count stays in [0, preset_q]; no arithmetic wrap is possible.
  - A dir change mid-count takes effect at the next edge or compare.
- preset changes while COUNTING or DONE are ignored until load or disable.
- preset_q=0:
  - Terminal is reached immediately; DONE is entered 1 cycle after enable or load.
  - With auto_reload=1, done toggles 1,0,1,0… (one DONE cycle, one COUNTING cycle).
- Disable mid-count: next cycle state=IDLE, done=0, overflow=0, count=start value.
- done is a registered output: done=1 exactly when state==DONE.

Optional Feature:
- Macro: VSLC_CTR_DEBOUNCE_EN.
- Defined:
  - count_in first passes through a 2-flop synchronizer and then a stability filter.
  - The filtered level changes only after the raw input has held the new value for DEBOUNCE_CYCLES consecutive cycles.
  - Filter output resets to 0.
  - Edge detection uses the filtered level, giving added latency of 2+DEBOUNCE_CYCLES cycles.
  - Pulses shorter than DEBOUNCE_CYCLES are dropped and are not flagged as overflow.
- Undefined: raw count_in feeds edge detection directly; no synchronizer, and no added latency.

Decomposition:
- Shared package vslc_pkg:
  - counter state encoding: IDLE=2'd0, COUNTING=2'd1, DONE=2'd2.
  - VSLC_WIDTH=8, shared with the timer.
  - default DEBOUNCE_CYCLES.
- Sub-module vslc_debounce:
  - synchronizer, stability counter and filtered output.
  - Instantiated only under VSLC_CTR_DEBOUNCE_EN.
  - Reusable for other VSLC pin inputs.

Test Plan:
- Up count, one-shot:
  - Stimulus: preset=3, dir=0, auto_reload=0, enable=1, then 3 count_in pulses.
  - Response: count 0→1→2→3; done=1 one cycle after count=3; a 4th pulse keeps count=3 and sets overflow=1; load clears overflow and sets count=0.
- Down count, auto-reload:
  - Stimulus: preset=2, dir=1, auto_reload=1, then 5 pulses spaced 4 cycles apart.
  - Response: count 2→1→0; done high for exactly 1 cycle; count reloads to 2; sequence repeats; overflow stays 0.
- preset=0 with auto_reload=1:
  - Response: done pattern 0,1,0,1… starting 1 cycle after enable; count stays 0.
- Enable while count_in high, then mid-count disable:
  - Stimulus: count_in=1 held, enable rises.
  - Response: no count.
  - Stimulus: then disable at count=2.
  - Response: next cycle count=0, done=0, overflow=0.
- Preset change mid-count:
  - Stimulus: preset 5→1 while count=2.
  - Response: terminal remains 5; after load, preset_q=1.
- Debounce (macro defined, DEBOUNCE_CYCLES=4):
  - Stimulus: a 3-cycle pulse, then a 6-cycle pulse.
  - Response: count increments only once, 6 cycles (2+4) after the second pulse's rising edge.

Source files
------------

// File: rtl/vslc_pkg.sv
// Shared VSLC definitions: counter state encoding, datapath width and
// the default debounce filter length.
package vslc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } vslc_ctr_state_e;

    // Datapath width shared with the VSLC timer.
    localparam int unsigned VSLC_WIDTH = 8;

    // Default stability filter length for debounced pin inputs.
    localparam int unsigned VSLC_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/vslc_debounce.sv
// Pin input conditioner: 2-flop synchronizer followed by a stability
// filter. The output level only changes after the synchronized input has
// held the new value for CYCLES consecutive clocks; it resets to 0.
module vslc_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] stable_q;

    // Synchronize the raw input, then accept a new level only after it is stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            stable_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                if (stable_q == CW'(CYCLES - 1)) begin
                    level_q  <= sync2_q;
                    stable_q <= '0;
                end else begin
                    stable_q <= stable_q + CW'(1);
                end
            end else begin
                stable_q <= '0;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/tt_um_jimktrains_vslc_counter.sv
// VSLC up/down preset counter. Counts rising edges of count_in, flags the
// terminal count and records dropped edges in a sticky overflow flag.
// Optional build macro VSLC_CTR_DEBOUNCE_EN routes count_in through
// vslc_debounce before edge detection.
module tt_um_jimktrains_vslc_counter
    import vslc_pkg::*;
#(
    parameter int unsigned WIDTH           = VSLC_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = VSLC_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_in,
    input  logic             enable,
    input  logic             dir,
    input  logic [WIDTH-1:0] preset,
    input  logic             load,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             overflow
);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    vslc_ctr_state_e  state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] preset_q;
    logic             count_in_q;
    logic             done_q;
    logic             overflow_q;

    logic             src_level;
    logic             edge_det;
    logic [WIDTH-1:0] start_new;
    logic [WIDTH-1:0] start_held;
    logic [WIDTH-1:0] terminal;

`ifdef VSLC_CTR_DEBOUNCE_EN
    vslc_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (count_in),
        .level_o(src_level)
    );
`else
    assign src_level = count_in;
`endif

    // Edge detect and start/terminal selection, all using the current dir.
    always_comb begin
        edge_det   = src_level & ~count_in_q;
        start_new  = dir ? preset   : '0;
        start_held = dir ? preset_q : '0;
        terminal   = dir ? '0       : preset_q;
    end

    // Counter FSM with registered count, done and overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            preset_q   <= '0;
            count_in_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_in_q <= src_level;
            if (!enable) begin
                state_q    <= IDLE;
                preset_q   <= preset;
                count_q    <= start_new;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else if (load) begin
                state_q    <= COUNTING;
                preset_q   <= preset;
                count_q    <= start_new;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Enabled straight out of IDLE: latch as a fresh start.
                        state_q  <= COUNTING;
                        preset_q <= preset;
                        count_q  <= start_new;
                        done_q   <= 1'b0;
                    end
                    COUNTING: begin
                        if (count_q == terminal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (edge_det) overflow_q <= 1'b1;
                        end else if (edge_det) begin
                            count_q <= dir ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                        end
                    end
                    DONE: begin
                        if (edge_det) overflow_q <= 1'b1;
                        if (auto_reload) begin
                            state_q <= COUNTING;
                            count_q <= start_held;
                            done_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count    = count_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_counter.sv
// Directed bench for tt_um_jimktrains_vslc_counter: a vector table for the
// up-count one-shot flow plus hand-written multi-cycle sequences.
module tb_tt_um_jimktrains_vslc_counter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         count_in;
    logic         enable;
    logic         dir;
    logic [W-1:0] preset;
    logic         load;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         done;
    logic         overflow;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic         en;
        logic         dr;
        logic         ar;
        logic         ld;
        logic [W-1:0] pre;
        logic         cin;
        logic [W-1:0] e_count;
        logic         e_done;
        logic         e_ovf;
    } vec_t;

    tt_um_jimktrains_vslc_counter #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .enable     (enable),
        .dir        (dir),
        .preset     (preset),
        .load       (load),
        .auto_reload(auto_reload),
        .count      (count),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input string name, input logic [W-1:0] ec,
                             input logic ed, input logic eo);
        check({name, ".count"}, 32'(count), 32'(ec));
        check({name, ".done"}, 32'(done), 32'(ed));
        check({name, ".overflow"}, 32'(overflow), 32'(eo));
    endtask

    vec_t vecs[12];

    initial begin
        rst_n = 1'b0; count_in = 1'b0; enable = 1'b0; dir = 1'b0;
        preset = 8'd0; load = 1'b0; auto_reload = 1'b0;
        step();
        step();
        check_all("reset", 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

`ifndef VSLC_CTR_DEBOUNCE_EN
        // Up count, one-shot, preset=3.
        //          en   dr   ar   ld   pre   cin   count done ovf
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b1, 8'd1,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd1,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b1, 8'd2,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd2,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b1, 8'd3,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd3,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b1, 8'd3,1'b1,1'b1};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd3,1'b1,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,8'd3,1'b0, 8'd0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,8'd3,1'b1, 8'd1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'd3,1'b0, 8'd0,1'b0,1'b0};
        for (int i = 0; i < 12; i++) begin
            enable = vecs[i].en; dir = vecs[i].dr; auto_reload = vecs[i].ar;
            load = vecs[i].ld; preset = vecs[i].pre; count_in = vecs[i].cin;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_done, vecs[i].e_ovf);
        end
        load = 1'b0;

        // Down count with auto-reload, preset=2, pulses every 4 cycles.
        begin
            logic [W-1:0] exp_c[20];
            logic         exp_d[20];
            exp_c = '{8'd1,8'd1,8'd1,8'd1, 8'd0,8'd0,8'd2,8'd2, 8'd1,8'd1,8'd1,8'd1,
                      8'd0,8'd0,8'd2,8'd2, 8'd1,8'd1,8'd1,8'd1};
            exp_d = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,
                      1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
            enable = 1'b0; preset = 8'd2; dir = 1'b1; auto_reload = 1'b1; count_in = 1'b0;
            step();
            check("down.idle_start", 32'(count), 32'd2);
            enable = 1'b1;
            step();
            check_all("down.enabled", 8'd2, 1'b0, 1'b0);
            for (int c = 0; c < 20; c++) begin
                count_in = (c % 4 == 0);
                step();
                check($sformatf("down.c%0d.count", c), 32'(count), 32'(exp_c[c]));
                check($sformatf("down.c%0d.done", c), 32'(done), 32'(exp_d[c]));
            end
            count_in = 1'b0;
            check("down.overflow", 32'(overflow), 32'd0);
        end

        // preset=0 with auto-reload: done alternates, count stays 0.
        enable = 1'b0; preset = 8'd0; dir = 1'b0; auto_reload = 1'b1;
        step();
        enable = 1'b1;
        step();
        check_all("p0.enabled", 8'd0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            check_all($sformatf("p0.c%0d", c), 8'd0, (c % 2 == 0), 1'b0);
        end

        // Enable while count_in is already high: no count.
        enable = 1'b0; preset = 8'd5; dir = 1'b0; auto_reload = 1'b0; count_in = 1'b1;
        step();
        enable = 1'b1;
        step();
        step();
        check_all("hi_en", 8'd0, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            count_in = 1'b0; step();
            count_in = 1'b1; step();
        end
        check("hi_en.count2", 32'(count), 32'd2);

        // Preset change mid-count is ignored: terminal stays 5.
        preset = 8'd1;
        for (int p = 0; p < 3; p++) begin
            count_in = 1'b0; step();
            count_in = 1'b1; step();
        end
        check_all("pchg.at5", 8'd5, 1'b0, 1'b0);
        count_in = 1'b0; step();
        check_all("pchg.done", 8'd5, 1'b1, 1'b0);

        // Load picks up preset=1.
        load = 1'b1; step(); load = 1'b0;
        check_all("pchg.load", 8'd0, 1'b0, 1'b0);
        count_in = 1'b1; step();
        count_in = 1'b0; step();
        check_all("pchg.done1", 8'd1, 1'b1, 1'b0);
        count_in = 1'b1; step();
        check_all("pchg.ovf", 8'd1, 1'b1, 1'b1);
        count_in = 1'b0;

        // Disable clears done/overflow and reloads start value.
        enable = 1'b0; step();
        check_all("dis.up", 8'd0, 1'b0, 1'b0);
        dir = 1'b1; step();
        check_all("dis.down", 8'd1, 1'b0, 1'b0);
`else
        // Debounced input: 3-cycle pulse dropped, 6-cycle pulse counted late.
        enable = 1'b0; preset = 8'd5; dir = 1'b0; auto_reload = 1'b0; count_in = 1'b0;
        for (int c = 0; c < 6; c++) step();
        enable = 1'b1; step();
        check_all("db.enabled", 8'd0, 1'b0, 1'b0);
        count_in = 1'b1;
        for (int c = 0; c < 3; c++) step();
        count_in = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check_all("db.short", 8'd0, 1'b0, 1'b0);
        count_in = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("db.before", 32'(count), 32'd0);
        step();
        check("db.after", 32'(count), 32'd1);
        count_in = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check_all("db.settled", 8'd1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
